rsa_req_arbiter: RTL and testbench
==================================

// Module: rsa_req_arbiter
// PURPOSE
//  Shares one RSA exponentiation core (RSA_pkg RSAModIn -> RSAModOut, valid/ready both sides) among
//  N_REQ requesters. Round-robin grant, one job in flight; the result returns to the granted requester.
//  Sits between requester ports and the single RSA core instance in the top level.
// PARAMETERS
//  N_REQ   4   number of requesters (2..16); ID_W = $clog2(N_REQ) localparam
//  CNT_W   16  width of per-requester completion counters (RSA_ARB_PERF_EN only)
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              reset, asynchronous, active-low
//  req_valid     in   N_REQ          per-requester job valid
//  req_ready     out  N_REQ          per-requester job accept (one-hot or zero)
//  req_in        in   N_REQ x RSAModIn  per-requester job {msg, key, modulus}
//  rsp_valid     out  N_REQ          per-requester result valid (one-hot or zero)
//  rsp_ready     in   N_REQ          per-requester result accept
//  rsp_out       out  RSAModOut      result bus shared by all requesters
//  core_i_valid  out  1              job valid to core
//  core_i_ready  in   1              core accepts job
//  core_i_in     out  RSAModIn       job to core (registered copy)
//  core_o_valid  in   1              core result valid
//  core_o_ready  out  1              result accept to core
//  core_o_out    in   RSAModOut      core result
//  busy          out  1              high when state != IDLE
//  owner         out  ID_W           requester holding the core (valid while busy)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, owner=0, job register=0, all valid/ready outputs 0, counters 0.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE; all outputs except req_ready/rsp_valid/core_o_ready/rsp_out are registered.
//  IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready[winner]=1 combinationally (only in IDLE); job transfers the same cycle.
//   - On transfer: latch req_in[winner] into job register, owner<=winner, rr_ptr<=(winner+1) mod N_REQ,
//     go to ISSUE. If there are no requests, stay in IDLE; rr_ptr is unchanged.
//  ISSUE: core_i_valid=1, core_i_in=job register (held stable). Move to WAIT on core_i_ready.
//   - Earliest core_i_valid is 1 cycle after acceptance.
//  WAIT: combinational pass-through of the core result.
//   - rsp_valid[owner]=core_o_valid; rsp_out=core_o_out; core_o_ready=rsp_ready[owner].
//   - On core_o_valid & rsp_ready[owner]: go to IDLE. A new grant is possible the next cycle.
//  Any state other than WAIT: rsp_valid=0, core_o_ready=0, rsp_out=0. Stray core results are not accepted.
//  Any state other than IDLE: req_ready=0. Requesters must hold req_valid/req_in until accepted.
//  A requester may drop req_valid before it is granted (no error); it is simply not considered.
//  All N_REQ requesting at once: service order is rr_ptr, rr_ptr+1, ... with no starvation.
//   - Worst-case wait is N_REQ-1 jobs.
//  Wrap-around: if winner = N_REQ-1, then rr_ptr <= 0.
//  Reset mid-operation: FSM returns to IDLE and the in-flight job is dropped.
//   - The core shares rst_n and is reset too; the requester is not notified.
//  core_i_ready and core_o_valid high in the same cycle: only the ISSUE->WAIT transition is taken.
//   - The result is consumed from the following cycle.
// CONFIGURATION
//  RSA_ARB_PERF_EN defined:
//   - adds output done_cnt [N_REQ*CNT_W]; slice i counts completed results of requester i
//     (increments on rsp_valid[i]&rsp_ready[i]).
//   - Counters saturate at 2^CNT_W-1, reset to 0, and are not cleared otherwise.
//  RSA_ARB_PERF_EN undefined: no done_cnt port and no counter logic; arbitration behaviour is identical.
// TESTING
//  1. Single job: req_valid=4'b0100, msg=0x2, key=0x3, mod=0xB, core model returns 0x8
//     -> req_ready[2] 1 cycle; core_i_valid next cycle; rsp_valid=4'b0100, rsp_out=0x8; busy falls after handshake.
//  2. All four requesting continuously from reset -> grant order 0,1,2,3,0,...
//     Each result appears only on its own rsp_valid bit.
//  3. Backpressure: core_i_ready low 5 cycles, then rsp_ready[owner] low 3 cycles
//     -> core_i_in stable; core_o_ready low; no new grant until the result handshake.
//  4. Wrap and skip: rr_ptr=3, req_valid=4'b0011 -> grant 0, then 1 (3 and 2 skipped); rr_ptr ends at 2.
//  5. rst_n asserted while in WAIT -> next cycle all outputs 0, busy=0; the following request is granted from requester 0.
//  6. RSA_ARB_PERF_EN: 3 jobs to requester 1 with CNT_W=2 -> done_cnt slice 1 = 3.
//     A 4th job keeps it at 3 (saturation); other slices stay 0.

Source files
------------

// File: rtl/rsa_req_arbiter.sv
// rsa_req_arbiter
//   Shares one RSA exponentiation core among N_REQ requesters. Round-robin
//   grant with one job in flight; the result is routed back to the requester
//   that owns the core.
//
//   Optional feature macro: RSA_ARB_PERF_EN adds per-requester saturating
//   completion counters on output done_cnt.
//
//   Parameters
//     N_REQ      number of requesters (2..16)
//     CNT_W      completion counter width (RSA_ARB_PERF_EN only)
//     RSAModIn   job type {msg, key, modulus}  (RSA_pkg::RSAModIn in the top level)
//     RSAModOut  result type                   (RSA_pkg::RSAModOut in the top level)
//
//   Ports
//     clk, rst_n      clock, asynchronous active-low reset
//     req_valid/ready per-requester job handshake (req_ready one-hot or zero)
//     req_in          per-requester job
//     rsp_valid/ready per-requester result handshake (rsp_valid one-hot or zero)
//     rsp_out         result bus shared by all requesters
//     core_i_*        job handshake towards the core (core_i_in registered)
//     core_o_*        result handshake from the core
//     busy            high while a job is in flight
//     owner           requester holding the core (valid while busy)
//     done_cnt        N_REQ x CNT_W completion counters (RSA_ARB_PERF_EN only)
module rsa_req_arbiter #(
   parameter int unsigned N_REQ = 4,
`ifdef RSA_ARB_PERF_EN
   parameter int unsigned CNT_W = 16,
`endif
   parameter type RSAModIn  = logic [95:0],
   parameter type RSAModOut = logic [31:0],
   localparam int unsigned ID_W = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  RSAModIn [N_REQ-1:0]   req_in,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output RSAModOut              rsp_out,
   output logic                  core_i_valid,
   input  logic                  core_i_ready,
   output RSAModIn               core_i_in,
   input  logic                  core_o_valid,
   output logic                  core_o_ready,
   input  RSAModOut              core_o_out,
   output logic                  busy,
   output logic [ID_W-1:0]       owner
`ifdef RSA_ARB_PERF_EN
   ,
   output logic [N_REQ*CNT_W-1:0] done_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   RSAModIn         job_q;

   logic            found;
   logic [ID_W-1:0] winner;
   logic [ID_W:0]   cand;

   // Scan rr_ptr, rr_ptr+1, ... modulo N_REQ; first active request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready    = '0;
      rsp_valid    = '0;
      core_o_ready = 1'b0;
      rsp_out      = '0;
      if (state == IDLE && found) begin
         req_ready[winner] = 1'b1;
      end
      if (state == WAIT) begin
         rsp_valid[owner] = core_o_valid;
         core_o_ready     = rsp_ready[owner];
         rsp_out          = core_o_out;
      end
   end

   assign core_i_in = job_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         job_q        <= '0;
         core_i_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  job_q        <= req_in[winner];
                  owner        <= winner;
                  rr_ptr       <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                  core_i_valid <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               // A result presented in the same cycle is consumed from WAIT onwards.
               if (core_i_ready) begin
                  core_i_valid <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (core_o_valid && rsp_ready[owner]) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               core_i_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

`ifdef RSA_ARB_PERF_EN
   for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (rsp_valid[i] && rsp_ready[i] && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
      assign done_cnt[i*CNT_W +: CNT_W] = cnt;
   end
`endif

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// tb_rsa_req_arbiter
//   Directed bench for rsa_req_arbiter: the core side is driven by hand, one
//   stimulus step per falling clock edge, outputs sampled 1 ns later.
//   Build with RSA_ARB_PERF_EN defined to also cover the completion counters.
module tb_rsa_req_arbiter;

   localparam int unsigned N = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0][95:0] req_in = '0;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready = '0;
   logic [31:0]       rsp_out;
   logic              core_i_valid;
   logic              core_i_ready = 1'b0;
   logic [95:0]       core_i_in;
   logic              core_o_valid = 1'b0;
   logic              core_o_ready;
   logic [31:0]       core_o_out = '0;
   logic              busy;
   logic [1:0]        owner;
`ifdef RSA_ARB_PERF_EN
   logic [7:0]        done_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rsa_req_arbiter #(
      .N_REQ(N)
`ifdef RSA_ARB_PERF_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
      .core_i_valid(core_i_valid), .core_i_ready(core_i_ready), .core_i_in(core_i_in),
      .core_o_valid(core_o_valid), .core_o_ready(core_o_ready), .core_o_out(core_o_out),
      .busy(busy), .owner(owner)
`ifdef RSA_ARB_PERF_EN
      , .done_cnt(done_cnt)
`endif
   );

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [95:0] job(input logic [31:0] m, input logic [31:0] k, input logic [31:0] md);
      return {m, k, md};
   endfunction

   // Entered 1 ns after a falling edge with req_valid already driven.
   // ci_wait: extra ISSUE cycles with core_i_ready low; ro_wait: WAIT cycles
   // with rsp_ready low; early: result presented together with core_i_ready.
   task automatic serve(input logic [3:0] g, input logic [95:0] jb, input logic [31:0] res,
                        input int ci_wait, input int ro_wait, input bit early);
      check("grant", req_ready, g);
      @(negedge clk); #1;
      check("issue_valid", core_i_valid, 1'b1);
      check("issue_job", core_i_in, jb);
      check("issue_busy", busy, 1'b1);
      check("issue_no_grant", req_ready, 4'b0000);
      for (int i = 0; i < ci_wait; i++) begin
         @(negedge clk); #1;
         check("bp_job_stable", core_i_in, jb);
         check("bp_valid_held", core_i_valid, 1'b1);
         check("bp_no_grant", req_ready, 4'b0000);
      end
      core_i_ready = 1'b1;
      if (early) begin
         core_o_valid = 1'b1;
         core_o_out   = res;
         rsp_ready    = g;
         #1;
         check("stray_core_o_ready", core_o_ready, 1'b0);
         check("stray_rsp_valid", rsp_valid, 4'b0000);
         check("stray_rsp_out", rsp_out, 32'd0);
      end
      @(negedge clk);
      core_i_ready = 1'b0;
      core_o_valid = 1'b1;
      core_o_out   = res;
      rsp_ready    = 4'b0000;
      #1;
      check("wait_core_i_valid", core_i_valid, 1'b0);
      for (int i = 0; i < ro_wait; i++) begin
         check("bp_rsp_valid", rsp_valid, g);
         check("bp_core_o_ready", core_o_ready, 1'b0);
         check("bp_no_grant2", req_ready, 4'b0000);
         @(negedge clk); #1;
      end
      rsp_ready = g;
      #1;
      check("rsp_valid", rsp_valid, g);
      check("rsp_out", rsp_out, res);
      check("core_o_ready", core_o_ready, 1'b1);
      @(negedge clk);
      core_o_valid = 1'b0;
      core_o_out   = '0;
      rsp_ready    = 4'b0000;
      #1;
      check("done_busy", busy, 1'b0);
      check("done_rsp_valid", rsp_valid, 4'b0000);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      req_valid    = '0;
      core_i_ready = 1'b0;
      core_o_valid = 1'b0;
      core_o_out   = '0;
      rsp_ready    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_core_i_valid", core_i_valid, 1'b0);
      check("rst_core_i_in", core_i_in, 96'd0);
      check("rst_owner", owner, 2'd0);
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_rsp_valid", rsp_valid, 4'b0000);
      check("rst_core_o_ready", core_o_ready, 1'b0);
      check("rst_rsp_out", rsp_out, 32'd0);

      // Single job to requester 2: 2^3 mod 11 = 8
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'b0100;
      req_in[2] = job(32'd2, 32'd3, 32'd11);
      #1;
      check("t1_busy_idle", busy, 1'b0);
      serve(4'b0100, job(32'd2, 32'd3, 32'd11), 32'd8, 0, 0, 1'b0);
      req_valid = '0;

      // All four requesting continuously from reset: grants 0,1,2,3,0
      do_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_in[i] = job(32'(i + 2), 32'd3, 32'd11);
      #1;
      begin
         logic [31:0] res_tab [4];
         res_tab = '{32'd8, 32'd5, 32'd9, 32'd4};
         for (int n = 0; n < 5; n++) begin
            serve(4'(1 << (n % 4)), job(32'((n % 4) + 2), 32'd3, 32'd11), res_tab[n % 4], 0, 0, 1'b0);
         end
      end

      // Backpressure: rr_ptr=1, requests {3,0} -> grant 3 (7^5 mod 13 = 11)
      req_valid = 4'b1001;
      req_in[3] = job(32'd7, 32'd5, 32'd13);
      #1;
      serve(4'b1000, job(32'd7, 32'd5, 32'd13), 32'd11, 5, 3, 1'b0);
      // Requester 0 next; result offered alongside core_i_ready
      serve(4'b0001, job(32'd2, 32'd3, 32'd11), 32'd8, 0, 0, 1'b1);
      req_valid = '0;

      // Wrap and skip: move rr_ptr to 3 via requester 2, then {0,1}
      req_valid = 4'b0100;
      #1;
      serve(4'b0100, job(32'd4, 32'd3, 32'd11), 32'd9, 0, 0, 1'b0);
      req_valid = 4'b0011;
      #1;
      serve(4'b0001, job(32'd2, 32'd3, 32'd11), 32'd8, 0, 0, 1'b0);
      serve(4'b0010, job(32'd3, 32'd3, 32'd11), 32'd5, 0, 0, 1'b0);
      req_valid = 4'b1111;
      #1;
      check("t4_rr_ptr_is_2", req_ready, 4'b0100);
      serve(4'b0100, job(32'd4, 32'd3, 32'd11), 32'd9, 0, 0, 1'b0);
      req_valid = '0;

      // Reset while in WAIT (rr_ptr would be 1 afterwards without reset)
      req_valid = 4'b0001;
      #1;
      check("t5_grant", req_ready, 4'b0001);
      @(negedge clk);
      req_valid    = '0;
      core_i_ready = 1'b1;
      @(negedge clk);
      core_i_ready = 1'b0;
      core_o_valid = 1'b1;
      core_o_out   = 32'd5;
      #1;
      check("t5_in_wait", rsp_valid, 4'b0001);
      rst_n = 1'b0;
      #1;
      check("t5_rst_rsp_valid", rsp_valid, 4'b0000);
      check("t5_rst_core_o_ready", core_o_ready, 1'b0);
      @(negedge clk);
      #1;
      check("t5_busy", busy, 1'b0);
      check("t5_core_i_valid", core_i_valid, 1'b0);
      check("t5_core_i_in", core_i_in, 96'd0);
      check("t5_owner", owner, 2'd0);
      check("t5_rsp_out", rsp_out, 32'd0);
      core_o_valid = 1'b0;
      core_o_out   = '0;
      rst_n        = 1'b1;
      req_valid    = 4'b1111;
      #1;
      serve(4'b0001, job(32'd2, 32'd3, 32'd11), 32'd8, 0, 0, 1'b0);
      req_valid = '0;

`ifdef RSA_ARB_PERF_EN
      // Completion counters, CNT_W=2: slice 1 saturates at 3
      do_reset();
      req_valid = 4'b0010;
      req_in[1] = job(32'd3, 32'd3, 32'd11);
      #1;
      check("t6_cnt_reset", done_cnt, 8'h00);
      begin
         logic [7:0] exp_cnt [4];
         exp_cnt = '{8'b00_00_01_00, 8'b00_00_10_00, 8'b00_00_11_00, 8'b00_00_11_00};
         for (int n = 0; n < 4; n++) begin
            serve(4'b0010, job(32'd3, 32'd3, 32'd11), 32'd5, 0, 0, 1'b0);
            check("t6_done_cnt", done_cnt, exp_cnt[n]);
         end
      end
      req_valid = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
